// File: rtl/reg_bank_param.sv
// Parameterised two-read/one-write register bank with byte strobes, optional
// hardwired zero entry, optional write forwarding and a one-entry-per-cycle clear sweep.
module reg_bank_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic [ADDR_W-1:0]     raddr1,
  input  logic [ADDR_W-1:0]     raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic [ADDR_W-1:0]   w_clr_ptr_nxt;
  logic                r_clr_done;
  logic                w_clr_done_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_wr_acc;
  logic [DATA_W-1:0]   w_wmask;
  logic [DATA_W-1:0]   w_merged;

  function automatic logic [DATA_W-1:0] f_lane_mask(input logic [NB-1:0] strb);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

  // Writes are dropped during the sweep and never touch the hardwired entry.
  assign w_wr_acc = (r_state == S_IDLE) && we && !((ZERO_REG != 0) && (waddr == '0));
  assign w_wmask  = f_lane_mask(wstrb);
  assign w_merged = (r_mem[waddr] & ~w_wmask) | (wdata & w_wmask);

  always_comb begin
    rdata1 = r_mem[raddr1];
    rdata2 = r_mem[raddr2];
    if ((BYPASS != 0) && w_wr_acc && (raddr1 == waddr)) rdata1 = w_merged;
    if ((BYPASS != 0) && w_wr_acc && (raddr2 == waddr)) rdata2 = w_merged;
    if ((ZERO_REG != 0) && (raddr1 == '0)) rdata1 = '0;
    if ((ZERO_REG != 0) && (raddr2 == '0)) rdata2 = '0;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_ptr_nxt  = r_clr_ptr;
    w_clr_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_nxt   = S_CLEAR;
          w_clr_ptr_nxt = '0;
        end
      end
      S_CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == '1) begin
          w_state_nxt    = S_IDLE;
          w_clr_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_clr_ptr  <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_ptr  <= w_clr_ptr_nxt;
      r_clr_done <= w_clr_done_nxt;
    end
  end

  // Sweep has priority over writes; the write path is already gated off in CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == S_CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr_acc) begin
      r_mem[waddr] <= w_merged;
    end
  end

  assign busy     = (r_state == S_CLEAR);
  assign clr_done = r_clr_done;

endmodule

// File: tb/tb_reg_bank_param.sv
// Randomised bench for reg_bank_param against a contents-array reference model.
module tb_reg_bank_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic          clr_req;
  logic          busy;
  logic          clr_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_busy;
  int          m_sweep;
  bit          m_done;

  reg_bank_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    if (a == 0) return 32'h0;
    if (rst_n && !m_busy && we && waddr != 0 && a == waddr) return merge(m_mem[a], wdata, wstrb);
    return m_mem[a];
  endfunction

  function automatic logic [31:0] fill_val(input int i);
    return 32'h1000_0000 + i * 32'h0101_0101 + 32'h77;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_busy  = 0;
    m_sweep = 0;
    m_done  = 0;
  endtask

  // Advance model across the coming rising edge, then return at the next falling edge.
  task automatic tick();
    bit fin;
    fin = 0;
    if (!rst_n) begin
      model_reset();
    end else if (m_busy) begin
      m_mem[m_sweep] = 32'h0;
      m_sweep++;
      if (m_sweep == DEPTH) begin
        m_busy = 0;
        fin    = 1;
      end
    end else begin
      if (we && waddr != 0) m_mem[waddr] = merge(m_mem[waddr], wdata, wstrb);
      if (clr_req) begin
        m_busy  = 1;
        m_sweep = 0;
      end
    end
    m_done = fin;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    we = 1'b1; waddr = a; wdata = d; wstrb = s;
    tick();
    we = 1'b0;
  endtask

  task automatic drain();
    clr_req = 1'b0;
    we      = 1'b0;
    for (int i = 0; i < 40 && m_busy; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++;
    if (clr_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %0b want 0", clr_done); end
    for (int a = 0; a < DEPTH; a++) begin
      raddr1 = AW'(a);
      raddr2 = AW'(DEPTH - 1 - a);
      #1;
      n_checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        n_errors++;
        $display("FAIL reset_read a=%0d: got %h/%h want 0/0", a, rdata1, rdata2);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (rdata1 !== 32'h0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset: rdata1=%h busy=%0b want 0/0", rdata1, busy);
    end
  endtask

  task automatic test_write_read();
    write(5'd5, 32'hDEADBEEF, 4'hF);
    raddr1 = 5'd5;
    #1;
    n_checks++;
    if (rdata1 !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL write_read: got %h want deadbeef", rdata1);
    end
  endtask

  task automatic test_bypass();
    write(5'd7, 32'h11223344, 4'hF);
    we = 1'b1; waddr = 5'd7; wdata = 32'hAABBCCDD; wstrb = 4'h5; raddr2 = 5'd7;
    #1;
    n_checks++;
    if (rdata2 !== 32'h11BB33DD) begin
      n_errors++; $display("FAIL bypass_same_cycle: got %h want 11bb33dd", rdata2);
    end
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (rdata2 !== 32'h11BB33DD) begin
      n_errors++; $display("FAIL bypass_after: got %h want 11bb33dd", rdata2);
    end
    we = 1'b1; waddr = 5'd7; wdata = 32'hFFFFFFFF; wstrb = 4'h0;
    #1;
    n_checks++;
    if (rdata2 !== 32'h11BB33DD) begin
      n_errors++; $display("FAIL zero_strobe_fwd: got %h want 11bb33dd", rdata2);
    end
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (rdata2 !== 32'h11BB33DD) begin
      n_errors++; $display("FAIL zero_strobe: got %h want 11bb33dd", rdata2);
    end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wstrb = 4'hF; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      n_errors++; $display("FAIL zero_reg_fwd: got %h/%h want 0/0", rdata1, rdata2);
    end
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin
      n_errors++; $display("FAIL zero_reg_after: got %h want 0", rdata1);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int i = 0; i < 300; i++) begin
      we      = ($urandom_range(0, 3) != 0);
      waddr   = AW'($urandom_range(0, DEPTH - 1));
      wdata   = $urandom;
      wstrb   = 4'($urandom_range(0, 15));
      clr_req = ($urandom_range(0, 99) == 0);
      raddr1  = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
      raddr2  = ($urandom_range(0, 1) == 0) ? raddr1 : AW'($urandom_range(0, DEPTH - 1));
      #1;
      e1 = model_read(raddr1);
      e2 = model_read(raddr2);
      n_checks++;
      if (rdata1 !== e1 || rdata2 !== e2) begin
        n_errors++;
        $display("FAIL random_read i=%0d a=%0d/%0d: got %h/%h want %h/%h",
                 i, raddr1, raddr2, rdata1, rdata2, e1, e2);
      end
      n_checks++;
      if (busy !== m_busy || clr_done !== m_done) begin
        n_errors++;
        $display("FAIL random_ctrl i=%0d: busy/done got %0b/%0b want %0b/%0b",
                 i, busy, clr_done, m_busy, m_done);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_clear();
    int busy_cycles;
    for (int a = 1; a < DEPTH; a++) write(AW'(a), fill_val(a), 4'hF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < DEPTH; c++) begin
      we = 1'b1; waddr = AW'($urandom_range(1, DEPTH - 1)); wdata = $urandom | 32'h1; wstrb = 4'hF;
      raddr1 = 5'd31;
      raddr2 = AW'(c);
      #1;
      if (busy === 1'b1) busy_cycles++;
      n_checks++;
      if (rdata1 !== fill_val(31)) begin
        n_errors++; $display("FAIL clear_keep31 c=%0d: got %h want %h", c, rdata1, fill_val(31));
      end
      n_checks++;
      if (rdata2 !== model_read(AW'(c)) || clr_done !== 1'b0) begin
        n_errors++;
        $display("FAIL clear_sweep c=%0d: got %h done=%0b want %h done=0",
                 c, rdata2, clr_done, model_read(AW'(c)));
      end
      tick();
    end
    we = 1'b0;
    #1;
    n_checks++;
    if (busy_cycles != DEPTH) begin
      n_errors++; $display("FAIL clear_busy_len: got %0d want %0d", busy_cycles, DEPTH);
    end
    n_checks++;
    if (busy !== 1'b0 || clr_done !== 1'b1) begin
      n_errors++; $display("FAIL clear_end: busy/done got %0b/%0b want 0/1", busy, clr_done);
    end
    tick();
    n_checks++;
    if (clr_done !== 1'b0) begin
      n_errors++; $display("FAIL clear_done_pulse: got %0b want 0", clr_done);
    end
    for (int a = 0; a < DEPTH; a++) begin
      raddr1 = AW'(a);
      raddr2 = AW'(a);
      #1;
      n_checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        n_errors++; $display("FAIL clear_all_zero a=%0d: got %h/%h want 0/0", a, rdata1, rdata2);
      end
    end
  endtask

  task automatic test_same_cycle();
    we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE0003; wstrb = 4'hF; clr_req = 1'b1;
    tick();
    we = 1'b0; clr_req = 1'b0; raddr1 = 5'd3;
    for (int j = 0; j < 4; j++) begin
      #1;
      n_checks++;
      if (rdata1 !== 32'hCAFE0003) begin
        n_errors++; $display("FAIL same_cycle_hold j=%0d: got %h want cafe0003", j, rdata1);
      end
      tick();
    end
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin
      n_errors++; $display("FAIL same_cycle_swept: got %h want 0", rdata1);
    end
    drain();
  endtask

  task automatic test_clr_held();
    clr_req = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) tick();
    #1;
    n_checks++;
    if (busy !== 1'b0 || clr_done !== 1'b1) begin
      n_errors++; $display("FAIL held_first_end: busy/done got %0b/%0b want 0/1", busy, clr_done);
    end
    tick();
    n_checks++;
    if (busy !== 1'b1 || clr_done !== 1'b0) begin
      n_errors++; $display("FAIL held_restart: busy/done got %0b/%0b want 1/0", busy, clr_done);
    end
    clr_req = 1'b0;
    for (int i = 0; i < 40 && busy === 1'b1; i++) tick();
    n_checks++;
    if (busy !== 1'b0 || clr_done !== 1'b1) begin
      n_errors++; $display("FAIL held_second_end: busy/done got %0b/%0b want 0/1", busy, clr_done);
    end
    drain();
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    for (int a = 1; a < DEPTH; a += 3) write(AW'(a), $urandom | 32'h100, 4'hF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (busy !== 1'b0 || clr_done !== 1'b0) begin
      n_errors++; $display("FAIL midreset_ctrl: busy/done got %0b/%0b want 0/0", busy, clr_done);
    end
    for (int a = 0; a < DEPTH; a++) begin
      raddr1 = AW'(a);
      raddr2 = AW'(a);
      #1;
      n_checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        n_errors++; $display("FAIL midreset_read a=%0d: got %h/%h want 0/0", a, rdata1, rdata2);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if (busy !== 1'b0 || clr_done !== 1'b0) begin
        n_errors++;
        $display("FAIL midreset_no_pulse i=%0d: busy/done got %0b/%0b want 0/0", i, busy, clr_done);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
    raddr1 = '0; raddr2 = '0; clr_req = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_random();
    test_clear();
    test_same_cycle();
    test_clr_held();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
